// File: rtl/sprite_geom_pkg.sv
// rtl/sprite_geom_pkg.sv - sprite geometry defaults, feeder state encoding and coordinate type
package sprite_geom_pkg;

  localparam int IMG_W_DFLT   = 48;
  localparam int IMG_H_DFLT   = 48;
  localparam int CENTER_DFLT  = 23;
  localparam int COORD_W_DFLT = 12;
  localparam int FRAC_W_DFLT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_FLUSH = 3'd4
  } feed_state_t;

  typedef logic signed [COORD_W_DFLT-1:0] coord_t;

endpackage

// File: rtl/sprite_coord_map.sv
// rtl/sprite_coord_map.sv - pixel index to centred signed fixed-point coordinate (SPRITE_FEED_HALF_OFFSET_EN adds +0.5 pixel)
module sprite_coord_map #(
  parameter int IDX_W   = 6,
  parameter int CENTER  = 23,
  parameter int COORD_W = 12,
  parameter int FRAC_W  = 4
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [COORD_W-1:0] coord
);

  // Working width is wide enough that the subtraction and shift never wrap
  // before the final truncation to the output width.
  localparam int FULL_W = (IDX_W + FRAC_W + 2 > COORD_W) ? (IDX_W + FRAC_W + 2) : COORD_W;
  localparam logic signed [FULL_W-1:0] CENTER_S = FULL_W'(CENTER);
`ifdef SPRITE_FEED_HALF_OFFSET_EN
  localparam logic signed [FULL_W-1:0] OFFSET_S = FULL_W'(1 << (FRAC_W - 1));
`else
  localparam logic signed [FULL_W-1:0] OFFSET_S = '0;
`endif

  logic signed [FULL_W-1:0] diff;
  logic signed [FULL_W-1:0] scaled;

  // Centre the index, scale to fixed point, apply optional pixel-centre offset.
  always_comb begin
    diff   = $signed({{(FULL_W-IDX_W){1'b0}}, idx}) - CENTER_S;
    scaled = (diff <<< FRAC_W) + OFFSET_S;
    coord  = scaled[COORD_W-1:0];
  end

endmodule

// File: rtl/sprite_point_feeder.sv
// rtl/sprite_point_feeder.sv - scans a one-bit sprite bitmap and streams set pixels as centred (x, y) points; option SPRITE_FEED_HALF_OFFSET_EN
module sprite_point_feeder
  import sprite_geom_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DFLT,
  parameter int IMG_H   = IMG_H_DFLT,
  parameter int CENTER  = CENTER_DFLT,
  parameter int COORD_W = COORD_W_DFLT,
  parameter int FRAC_W  = FRAC_W_DFLT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(IMG_H)-1:0]             row_addr,
  output logic                                 row_rd,
  input  logic [IMG_W-1:0]                     row_data,
  output logic                                 pt_valid,
  input  logic                                 pt_ready,
  output logic [COORD_W-1:0]                   pt_x,
  output logic [COORD_W-1:0]                   pt_y,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]     pt_count
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int CNT_W = $clog2(IMG_W*IMG_H+1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);

  feed_state_t state, next_state;

  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [IMG_W-1:0]   row_buf;
  logic [COORD_W-1:0] map_x;
  logic [COORD_W-1:0] map_y;

  logic slot_free;
  logic frame_start;
  logic load;
  logic advance;
  logic done_set;

  // The output register can take a new point when empty or being drained this cycle.
  assign slot_free = !pt_valid || pt_ready;
  assign busy      = (state != ST_IDLE);
  assign row_rd    = (state == ST_FETCH);
  assign row_addr  = row;

  sprite_coord_map #(
    .IDX_W   (COL_W),
    .CENTER  (CENTER),
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W)
  ) u_map_x (
    .idx   (col),
    .coord (map_x)
  );

  sprite_coord_map #(
    .IDX_W   (ROW_W),
    .CENTER  (CENTER),
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W)
  ) u_map_y (
    .idx   (row),
    .coord (map_y)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and per-cycle control: one column per SCAN cycle, stall on a full slot.
  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    done_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          next_state  = ST_FETCH;
        end
      end
      ST_FETCH: next_state = ST_WAIT;
      ST_WAIT:  next_state = ST_SCAN;
      ST_SCAN: begin
        if (row_buf[col]) begin
          if (slot_free) begin
            load    = 1'b1;
            advance = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance && (col == COL_MAX))
          next_state = (row == ROW_MAX) ? ST_FLUSH : ST_FETCH;
      end
      ST_FLUSH: begin
        if (slot_free) begin
          done_set   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Scan position, captured row and the registered done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row     <= '0;
      col     <= '0;
      row_buf <= '0;
      done    <= 1'b0;
    end else begin
      done <= done_set;
      if (frame_start) begin
        row <= '0;
        col <= '0;
      end else if (state == ST_WAIT) begin
        row_buf <= row_data;
        col     <= '0;
      end else if (advance) begin
        if (col == COL_MAX) begin
          col <= '0;
          if (row != ROW_MAX) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Output slot: load a new point, or clear on acceptance; hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
    end else if (load) begin
      pt_valid <= 1'b1;
      pt_x     <= map_x;
      pt_y     <= map_y;
    end else if (pt_ready) begin
      pt_valid <= 1'b0;
    end
  end

  // Accepted-point counter, cleared only when a new frame starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    pt_count <= '0;
    else if (frame_start)          pt_count <= '0;
    else if (pt_valid && pt_ready) pt_count <= pt_count + 1'b1;
  end

endmodule

// File: tb/tb_sprite_point_feeder.sv
// tb/tb_sprite_point_feeder.sv - scoreboard bench for sprite_point_feeder (honours SPRITE_FEED_HALF_OFFSET_EN)
module tb_sprite_point_feeder;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
  } pt_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [5:0]  row_addr;
  logic        row_rd;
  logic [47:0] row_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [11:0] pt_x;
  logic [11:0] pt_y;
  logic [11:0] pt_count;

  logic [47:0] mem [48];
  pt_t         exp_q[$];
  logic        rdy_q[$];
  logic        rdy_low;

  int n_checks;
  int n_pass;
  int cyc;
  int done_cnt;
  int done_cyc;
  int fetch_cyc;
  int fetch_row;
  int first_valid_cyc;
  int n_acc;
  int nexp;
  logic [11:0] first_x, first_y, last_x, last_y;

  sprite_point_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .row_addr (row_addr),
    .row_rd   (row_rd),
    .row_data (row_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_x     (pt_x),
    .pt_y     (pt_y),
    .pt_count (pt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [11:0] exp_coord(input int idx);
    int v;
    v = (idx - 23) * 16;
`ifdef SPRITE_FEED_HALF_OFFSET_EN
    v = v + 8;
`endif
    return 12'(v);
  endfunction

  // Sprite memory: one-cycle read latency.
  initial begin
    row_data = '0;
    forever begin
      @(posedge clk);
      if (row_rd) row_data <= mem[row_addr];
    end
  end

  // Downstream ready: pattern entries are consumed only on cycles with a valid point.
  initial begin
    pt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_low)                              pt_ready = 1'b0;
      else if (pt_valid && rdy_q.size() != 0)   pt_ready = rdy_q.pop_front();
      else                                      pt_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pop on acceptance, stall hold checks, event timestamps.
  initial begin
    logic prev_stall;
    logic [11:0] px, py;
    pt_t e;
    prev_stall = 1'b0;
    px = '0;
    py = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (row_rd && fetch_cyc < 0) begin
          fetch_cyc = cyc;
          fetch_row = int'(row_addr);
        end
        if (pt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_stall) begin
          chk("hold_valid", pt_valid, 1);
          chk("hold_x", pt_x, px);
          chk("hold_y", pt_y, py);
        end
        if (pt_valid && pt_ready) begin
          chk("pt_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pt_x", pt_x, e.x);
            chk("pt_y", pt_y, e.y);
            if (n_acc == 0) begin
              first_x = pt_x;
              first_y = pt_y;
            end
            last_x = pt_x;
            last_y = pt_y;
            n_acc++;
          end
        end
        prev_stall = pt_valid && !pt_ready;
        px = pt_x;
        py = pt_y;
      end
    end
  end

  task automatic clear_mem();
    for (int r = 0; r < 48; r++) mem[r] = '0;
  endtask

  task automatic run_frame(input string tag, input bit extra_start);
    int k;
    nexp = 0;
    for (int r = 0; r < 48; r++)
      for (int c = 0; c < 48; c++)
        if (mem[r][c]) begin
          exp_q.push_back('{x: exp_coord(c), y: exp_coord(r)});
          nexp++;
        end
    done_cnt        = 0;
    done_cyc        = -1;
    fetch_cyc       = -1;
    fetch_row       = -1;
    first_valid_cyc = -1;
    n_acc           = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_hi"}, busy, 1);
    if (extra_start) begin
      repeat (100) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (1000) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_pt_count"}, pt_count, nexp);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_pass   = 0;
    rdy_low  = 1'b0;
    done_cnt = 0;
    fetch_cyc = -1;
    first_valid_cyc = -1;
    n_acc    = 0;
    start    = 1'b0;
    reset    = 1'b0;
    clear_mem();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row_rd", row_rd, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_x", pt_x, 0);
    chk("rst_pt_y", pt_y, 0);
    chk("rst_pt_count", pt_count, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Corner pixels, ready always high
    clear_mem();
    mem[0][0]   = 1'b1;
    mem[47][47] = 1'b1;
    run_frame("corner", 1'b0);
`ifdef SPRITE_FEED_HALF_OFFSET_EN
    chk("corner_first_x", first_x, 12'hE98);
    chk("corner_first_y", first_y, 12'hE98);
    chk("corner_last_x", last_x, 12'h188);
    chk("corner_last_y", last_y, 12'h188);
`else
    chk("corner_first_x", first_x, 12'hE90);
    chk("corner_first_y", first_y, 12'hE90);
    chk("corner_last_x", last_x, 12'h180);
    chk("corner_last_y", last_y, 12'h180);
`endif
    chk("corner_first_valid_lat", first_valid_cyc - fetch_cyc, 3);
    chk("corner_done_lat", done_cyc - fetch_cyc, 48 * 50 + 1);

    // Raster order with backpressure pattern 1,0,0,1,1
    clear_mem();
    mem[5][3] = 1'b1;
    mem[5][4] = 1'b1;
    mem[6][0] = 1'b1;
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    run_frame("stall", 1'b0);
    chk("stall_n_acc", n_acc, 3);
    rdy_q.delete();

    // Empty bitmap: exact frame length and no points
    clear_mem();
    run_frame("empty", 1'b0);
    chk("empty_done_lat", done_cyc - fetch_cyc, 48 * 50 + 1);
    chk("empty_no_valid", first_valid_cyc, -1);

    // Random bitmap with start re-pulsed mid-frame
    clear_mem();
    for (int r = 0; r < 48; r++)
      mem[r] = 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()});
    run_frame("restart", 1'b1);

    // Reset mid-frame while a point is held
    clear_mem();
    mem[2] = '1;
    rdy_low  = 1'b1;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!pt_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("mf_valid_seen", pt_valid, 1);
    chk("mf_pt_x_set", pt_x, exp_coord(0));
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("mf_busy", busy, 0);
    chk("mf_done", done, 0);
    chk("mf_row_rd", row_rd, 0);
    chk("mf_row_addr", row_addr, 0);
    chk("mf_pt_valid", pt_valid, 0);
    chk("mf_pt_x", pt_x, 0);
    chk("mf_pt_y", pt_y, 0);
    chk("mf_pt_count", pt_count, 0);
    repeat (4) @(negedge clk);
    exp_q.delete();
    rdy_low = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("mf_no_done", done_cnt, 0);

    // Restart after reset rescans from row 0
    clear_mem();
    mem[0][0] = 1'b1;
    mem[1][9] = 1'b1;
    run_frame("post_rst", 1'b0);
    chk("post_rst_first_row", fetch_row, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
